// File: rtl/alu_bit_serial_seq.sv
// Bit-serial sequencer around an external 1-bit ALU: feeds operands LSB-first,
// chains carry/borrow between bits and assembles a WIDTH-bit result.
module alu_bit_serial_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag,
  output logic             zero,
  output logic             alu_a0,
  output logic             alu_b0,
  output logic             alu_c_in,
  output logic             alu_b_in,
  output logic [2:0]       alu_sel,
  input  logic             alu_y,
  input  logic             alu_c_out,
  input  logic             alu_b_out
);

  localparam int unsigned CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [2:0]  OP_ADD = 3'b000;
  localparam logic [2:0]  OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic               chain_q, chain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               flag_q, flag_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // State and datapath registers, cleared asynchronously on rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      chain_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      chain_q  <= chain_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    chain_d  = chain_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flag_d   = flag_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          a_d      = a;
          b_d      = b;
          op_d     = op;
          chain_d  = 1'b0;
          cnt_d    = '0;
          result_d = '0;
          flag_d   = 1'b0;
          zero_d   = 1'b0;
          busy_d   = 1'b1;
        end
      end
      S_RUN: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        result_d = {alu_y, result_q[WIDTH-1:1]};
        if (op_q == OP_ADD) begin
          chain_d = alu_c_out;
        end else if (op_q == OP_SUB) begin
          chain_d = alu_b_out;
        end else begin
          chain_d = 1'b0;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          flag_d  = chain_d;
          zero_d  = (result_d == '0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ALU drive: decoded from registered state, forced to 0 outside RUN
  always_comb begin
    alu_a0   = 1'b0;
    alu_b0   = 1'b0;
    alu_c_in = 1'b0;
    alu_b_in = 1'b0;
    alu_sel  = 3'b000;
    if (state_q == S_RUN) begin
      alu_a0  = a_q[0];
      alu_b0  = b_q[0];
      alu_sel = op_q;
      if (op_q == OP_ADD) begin
        alu_c_in = chain_q;
      end else if (op_q == OP_SUB) begin
        // the ALU's difference term reads c_in, so the borrow goes on both pins
        alu_c_in = chain_q;
        alu_b_in = chain_q;
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flag   = flag_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// Self-checking bench for alu_bit_serial_seq with a behavioural 1-bit ALU
// attached and an arithmetic reference model for whole-word results.
module tb_alu_bit_serial_seq;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag;
  logic             zero;
  logic             alu_a0;
  logic             alu_b0;
  logic             alu_c_in;
  logic             alu_b_in;
  logic [2:0]       alu_sel;
  logic             alu_y;
  logic             alu_c_out;
  logic             alu_b_out;

  int n_checks = 0;
  int n_fail   = 0;

  alu_bit_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .flag     (flag),
    .zero     (zero),
    .alu_a0   (alu_a0),
    .alu_b0   (alu_b0),
    .alu_c_in (alu_c_in),
    .alu_b_in (alu_b_in),
    .alu_sel  (alu_sel),
    .alu_y    (alu_y),
    .alu_c_out(alu_c_out),
    .alu_b_out(alu_b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External 1-bit ALU
  always_comb begin
    alu_y     = 1'b0;
    alu_c_out = 1'b0;
    alu_b_out = 1'b0;
    case (alu_sel)
      3'b000: begin
        alu_y     = alu_a0 ^ alu_b0 ^ alu_c_in;
        alu_c_out = (alu_a0 & alu_b0) | (alu_c_in & (alu_a0 ^ alu_b0));
      end
      3'b001: begin
        alu_y     = alu_a0 ^ alu_b0 ^ alu_c_in;
        alu_b_out = (~alu_a0 & alu_b0) | (~(alu_a0 ^ alu_b0) & alu_b_in);
      end
      3'b010: alu_y = alu_a0 & alu_b0;
      3'b011: alu_y = ~(alu_a0 | alu_b0);
      3'b111: alu_y = alu_a0 ^ alu_b0;
      default: alu_y = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: plain arithmetic on the operands
  task automatic ref_model(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                           input logic [2:0] rop,
                           output logic [WIDTH-1:0] rres, output logic rflag);
    logic [WIDTH:0] wide;
    rres  = '0;
    rflag = 1'b0;
    case (rop)
      3'b000: begin
        wide  = {1'b0, ra} + {1'b0, rb};
        rres  = wide[WIDTH-1:0];
        rflag = wide[WIDTH];
      end
      3'b001: begin
        rres  = ra - rb;
        rflag = (ra < rb);
      end
      3'b010: rres = ra & rb;
      3'b011: rres = ~(ra | rb);
      3'b111: rres = ra ^ rb;
      default: rres = '0;
    endcase
  endtask

  // Issue one operation from IDLE, follow it to done and check everything
  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input logic [2:0] top);
    logic [WIDTH-1:0] e_res;
    logic             e_flag;
    int               edges;
    int               busy_cnt;
    ref_model(ta, tb_v, top, e_res, e_flag);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v; op = top;
    @(posedge clk); #1;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); op = 3'($urandom);
    check("start_clears_flag", 32'(flag), 32'd0);
    check("start_clears_zero", 32'(zero), 32'd0);
    edges    = 1;
    busy_cnt = 0;
    while (!done && edges < 3 * WIDTH) begin
      if (busy) begin
        busy_cnt++;
        check("alu_sel_latched", 32'(alu_sel), 32'(top));
        if (top == 3'b001) check("sub_bin_eq_cin", 32'(alu_b_in), 32'(alu_c_in));
        else check("bin_zero", 32'(alu_b_in), 32'd0);
        if (top != 3'b000 && top != 3'b001) check("cin_zero", 32'(alu_c_in), 32'd0);
      end
      @(posedge clk); #1;
      edges++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("start_to_done", 32'(edges), 32'(WIDTH + 1));
    check("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
    check("busy_low_at_done", 32'(busy), 32'd0);
    check("result", 32'(result), 32'(e_res));
    check("flag", 32'(flag), 32'(e_flag));
    check("zero", 32'(zero), 32'(e_res == '0));
    check("alu_idle_sel", 32'(alu_sel), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("result_held", 32'(result), 32'(e_res));
  endtask

  initial begin
    logic [WIDTH-1:0] e_res;
    logic             e_flag;
    int               edges;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flag", 32'(flag), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_alu", 32'({alu_a0, alu_b0, alu_c_in, alu_b_in, alu_sel}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases
    do_op(8'h5A, 8'hC3, 3'b000);
    do_op(8'h10, 8'h01, 3'b001);
    do_op(8'h01, 8'h02, 3'b001);
    do_op(8'hF0, 8'h3C, 3'b010);
    do_op(8'hF0, 8'h0F, 3'b011);
    do_op(8'hAA, 8'hFF, 3'b111);
    do_op(8'hFF, 8'hFF, 3'b100);
    do_op(8'h00, 8'h00, 3'b000);
    do_op(8'hFF, 8'h01, 3'b000);
    do_op(8'h00, 8'h01, 3'b001);

    // Randomized operations across legal and illegal selects
    for (int i = 0; i < 24; i++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 7)));
    end

    // Start while busy is ignored
    @(negedge clk);
    start = 1'b1; a = 8'h33; b = 8'h11; op = 3'b000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    start = 1'b1; a = 8'h77; b = 8'h99; op = 3'b001;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_ignored_start", 32'(busy), 32'd1);
    edges = 0;
    while (!done && edges < 3 * WIDTH) begin
      @(posedge clk); #1;
      edges++;
    end
    check("ignored_done_seen", 32'(done), 32'd1);
    check("ignored_result", 32'(result), 32'h44);
    check("ignored_flag", 32'(flag), 32'd0);
    @(posedge clk); #1;
    do_op(8'h81, 8'h80, 3'b000);

    // Asynchronous reset during RUN
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF; op = 3'b000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_alu", 32'({alu_a0, alu_b0, alu_c_in, alu_b_in, alu_sel}), 32'd0);
    edges = 0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        @(negedge clk);
        rst = 1'b0;
      end
      if (done) edges++;
    end
    check("no_done_after_rst", 32'(edges), 32'd0);
    ref_model(8'h01, 8'h01, 3'b000, e_res, e_flag);
    check("ref_sanity_sum", 32'(e_res), 32'h02);
    do_op(8'h01, 8'h01, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_bit_serial_seq.md
Name: alu_bit_serial_seq

Overview:
Bit-serial sequencer that sits directly around the team's 1-bit ALU. It drives the ALU LSB-first over WIDTH cycles and chains carry/borrow from one bit into the next. It collects the ALU's y output into a WIDTH-bit result and reports completion with a done pulse. Its upstream is any control logic issuing start/op/operands; the 1-bit ALU is instantiated outside this block and connected through the alu_* ports.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
op  input  3  ALU select: 000 add, 001 sub, 010 and, 011 nor, 111 xor; others illegal
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse when result/flag/zero become valid
result  output  WIDTH  assembled result, held until next accepted start
flag  output  1  carry-out (add), borrow-out (sub), 0 for all other ops
zero  output  1  high when result == 0; valid with done, held afterwards
alu_a0  output  1  current bit of A to ALU
alu_b0  output  1  current bit of B to ALU
alu_c_in  output  1  chained carry (add) / borrow (sub) to ALU
alu_b_in  output  1  chained borrow to ALU (sub only)
alu_sel  output  3  op to ALU
alu_y  input  1  ALU result bit
alu_c_out  input  1  ALU carry-out
alu_b_out  input  1  ALU borrow-out

Behaviour:
- One clock (clk); rst is asynchronous and active-high. All state and outputs reach reset values immediately on rst assertion, independent of clk.
- Reset values: state=IDLE, busy=0, done=0, result=0, flag=0, zero=0, chain register=0, bit counter=0. All alu_* outputs are 0.
- States:
  - IDLE: waits for start.
  - RUN: processes one bit per cycle for exactly WIDTH cycles.
  - DONE: lasts exactly one cycle, done=1, then returns to IDLE.
- IDLE -> RUN on a clk edge with start=1:
  - latch a, b, op into shift registers;
  - clear the chain register and the counter.
  - start is ignored in RUN and DONE; there is no queueing.
- RUN, each cycle:
  - alu_a0/alu_b0 = LSB of the A/B shift registers.
  - alu_sel = latched op.
  - add: alu_c_in = chain, alu_b_in = 0.
  - sub: alu_c_in = chain AND alu_b_in = chain. The ALU's diff term uses c_in, so both pins carry the borrow.
  - logic and illegal ops: alu_c_in = alu_b_in = 0.
- RUN, on each clk edge:
  - shift alu_y into the result MSB and shift the result right;
  - shift the A/B registers right;
  - chain <= alu_c_out (add) or alu_b_out (sub), else 0;
  - increment the counter.
- After the WIDTH-th RUN edge -> DONE:
  - result holds all bits, with bit 0 = first processed;
  - flag = final chain;
  - zero = (result == 0).
- Outputs outside RUN: alu_* outputs are all 0.
- Latency: start sampled at edge 0 -> busy high for edges 1..WIDTH -> done high in the cycle after edge WIDTH. Start-to-done is WIDTH+1 cycles. Back-to-back throughput is WIDTH+2 cycles per op (the next start is accepted in IDLE).
- result, flag and zero stay stable from DONE until the next accepted start. They clear to 0 on that start edge.
- Illegal op (100/101/110): the sequence runs normally. The ALU returns 0, so result=0, zero=1, flag=0.
- Operand inputs a, b, op may change freely after acceptance; only latched copies are used.
- Reset mid-RUN or mid-DONE aborts the operation: no done pulse, outputs go to reset values, and the block accepts start on the first edge after rst deasserts.

Test Plan:
- Add carry, WIDTH=8: op=000, a=0x5A, b=0xC3 -> done 9 cycles after start, result=0x1D, flag=1, zero=0; busy high exactly 8 cycles.
- Sub, two cases:
  - op=001, a=0x10, b=0x01 -> result=0x0F, flag=0.
  - a=0x01, b=0x02 -> result=0xFF, flag=1. Check alu_b_in==alu_c_in every RUN cycle.
- Logic ops:
  - op=010, a=0xF0, b=0x3C -> result=0x30.
  - op=011, a=0xF0, b=0x0F -> result=0x00, zero=1.
  - op=111, a=0xAA, b=0xFF -> result=0x55. flag=0 in all three.
- Illegal op=100, a=0xFF, b=0xFF -> result=0x00, zero=1, flag=0, done after 9 cycles.
- Start while busy: second start with different operands at RUN cycle 3 -> ignored, first result unchanged; a start presented in the cycle after done is accepted.
- Async reset: assert rst at RUN cycle 4 between edges -> busy/result/alu_* go to 0 immediately, no done pulse; a fresh add 0x01+0x01 then yields result=0x02.
